// File: rtl/deserializer.sv
// Serial-to-parallel stage: collects MSB-first valid bursts into left-aligned
// DATA_W-bit words and reports the bit count with DATA_W encoded as 0.
module deserializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] data_o,
  output logic [MOD_W-1:0]  data_mod_o,
  output logic              data_val_o,
  output logic              busy_o
);

  localparam logic [MOD_W-1:0] LAST_CNT = MOD_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr;
  logic [MOD_W-1:0]  cnt;
  logic [MOD_W-1:0]  pos;

  // The first bit of a word lands in the MSB; later bits fill downward.
  assign pos = LAST_CNT - cnt;

  // Accumulate bits and emit a word on the full-word edge or on the first
  // invalid cycle after a partial burst. The completing bit of a full word is
  // merged directly into data_o, so a following bit starts a fresh word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr         <= '0;
      cnt        <= '0;
      data_o     <= '0;
      data_mod_o <= '0;
      data_val_o <= 1'b0;
    end else begin
      data_val_o <= 1'b0;
      if (ser_data_val_i) begin
        if (cnt == LAST_CNT) begin
          data_o     <= {sr[DATA_W-1:1], ser_data_i};
          data_mod_o <= '0;
          data_val_o <= 1'b1;
          sr         <= '0;
          cnt        <= '0;
        end else begin
          sr[pos] <= ser_data_i;
          cnt     <= cnt + MOD_W'(1);
        end
      end else if (cnt != '0) begin
        data_o     <= sr;
        data_mod_o <= cnt;
        data_val_o <= 1'b1;
        sr         <= '0;
        cnt        <= '0;
      end
    end
  end

  // Busy reflects registered state only: a partial word is pending.
  assign busy_o = (cnt != '0);

endmodule
